// File: rtl/sincos_arb.sv
// Two-requester arbiter in front of a shared sine/cosine unit.
// Alternates ties, issues one job at a time and aborts a job whose unit never answers.
module sincos_arb #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_opx,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_opx,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_sin,
  output logic [31:0] rsp_cos,
  output logic        rsp_err,
  output logic        u_start,
  output logic [31:0] u_opx,
  input  logic        u_done,
  input  logic [31:0] u_sin,
  input  logic [31:0] u_cos,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The counter is checked before it increments, so the job gets TIMEOUT_CYC WAIT cycles.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        last;
  logic        id;
  logic [31:0] opx_q;
  logic [31:0] sin_q;
  logic [31:0] cos_q;
  logic        err_q;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        expire;

  // On a tie the requester not served last wins; last resets to 1 so requester 0 wins first.
  assign grant0 = req0_valid & (~req1_valid | last);
  assign grant1 = req1_valid & (~req0_valid | ~last);
  assign accept = (state == IDLE) & (grant0 | grant1);
  assign expire = (state == WAIT) & ~u_done & (cnt == LIMIT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (u_done || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt   <= '0;
      last  <= 1'b1;
      id    <= 1'b0;
      opx_q <= '0;
      sin_q <= '0;
      cos_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opx_q <= grant0 ? req0_opx : req1_opx;
            id    <= grant1;
            last  <= grant1;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 8'd1;
          // A done in the limit cycle still counts as a real result.
          if (u_done) begin
            sin_q <= u_sin;
            cos_q <= u_cos;
            err_q <= 1'b0;
          end else if (cnt == LIMIT) begin
            sin_q <= '0;
            cos_q <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign u_start    = (state == ISSUE);
  assign u_opx      = opx_q;
  assign rsp0_valid = (state == RESP) & ~id;
  assign rsp1_valid = (state == RESP) & id;
  assign rsp_sin    = sin_q;
  assign rsp_cos    = cos_q;
  assign rsp_err    = err_q;
  assign busy       = (state != IDLE);

endmodule

// File: doc/sincos_arb.md
SINCOS_ARB -- requirements
Module: sincos_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the maximum number of WAIT cycles before a job is aborted (range 1..255).
REQ-002 SHALL have port clk, input, 1, the system clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port n_rst, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, requester N has an operand pending.
REQ-005 SHALL have ports req0_opx and req1_opx, input, 32 each, the IEEE-754 single-precision angle from requester N.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each, the request is accepted this cycle.
REQ-007 SHALL have ports rsp0_valid and rsp1_valid, output, 1 each, a one-cycle result pulse to requester N.
REQ-008 SHALL have ports rsp_sin and rsp_cos, output, 32 each, result data shared by both requesters and qualified by rspN_valid.
REQ-009 SHALL have port rsp_err, output, 1, set when the result was produced by a timeout abort; qualified by rspN_valid.
REQ-010 SHALL have ports u_start (output, 1) and u_opx (output, 32), the start pulse and operand driven to the shared sine/cosine unit.
REQ-011 SHALL have ports u_done (input, 1), u_sin (input, 32) and u_cos (input, 32), the unit's completion pulse and its results.
REQ-012 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-014 In IDLE, reqN_ready SHALL be asserted combinationally for the granted requester only; both ready outputs SHALL be 0 in all other states.
REQ-015 Grant: if only one reqN_valid is high, that requester SHALL win; if both are high, the requester not served by the most recent accepted job SHALL win; after reset, requester 0 SHALL win a tie.
REQ-016 On acceptance (reqN_valid and reqN_ready), the block SHALL register opx and the winner ID, update the last-served pointer, and move to ISSUE.
REQ-017 ISSUE SHALL last exactly one cycle, with u_start=1 and u_opx equal to the registered operand; the next state SHALL be WAIT.
REQ-018 u_opx SHALL hold the registered operand from ISSUE through RESP; u_start SHALL be 0 outside ISSUE.
REQ-019 In WAIT, an 8-bit counter SHALL start at 0 and increment each cycle; u_done=1 SHALL capture u_sin and u_cos, clear the error flag, and move to RESP.
REQ-020 If the counter reaches TIMEOUT_CYC in WAIT without u_done, the block SHALL load 0 into both results, set the error flag, and move to RESP; if u_done and the limit occur in the same cycle, u_done SHALL take priority.
REQ-021 RESP SHALL last exactly one cycle, asserting rspN_valid for the registered winner only, with rsp_sin, rsp_cos and rsp_err driven from the captured registers; the next state SHALL be IDLE.
REQ-022 u_done SHALL be ignored outside WAIT, including a late done that arrives after a timeout.
REQ-023 rsp_sin, rsp_cos and rsp_err SHALL hold their last values between responses.
REQ-024 Minimum latency SHALL be: accept at cycle T, u_start at T+1, u_done earliest at T+2, rspN_valid at T+3; the next acceptance SHALL be possible at T+4.
REQ-025 A request deasserted before acceptance SHALL be dropped without side effect; a requester SHALL hold valid and opx stable until it sees ready.

Reset
REQ-026 While n_rst=0, the block SHALL set the state to IDLE and clear the counter, error flag, last-served pointer (points to requester 1), operand, result registers, u_start, u_opx, rsp_sin, rsp_cos, rsp_err, both rspN_valid and busy.
REQ-027 Reset asserted in any state SHALL abort the job in flight with no response pulse; a u_done arriving after reset release SHALL be ignored.

Verification
REQ-028 Single job: req0_valid with opx=0x3FC90FDB (pi/2) -> req0_ready at T, u_start with u_opx=0x3FC90FDB at T+1; stub returns u_done with sin=0x3F800000 and cos=0x00000000 at T+2 -> rsp0_valid at T+3 with rsp_err=0.
REQ-029 Contention: both valid continuously, 4 jobs -> grants alternate 0,1,0,1; each rspN_valid goes to the matching requester.
REQ-030 Timeout: TIMEOUT_CYC=4, stub never returns done -> rspN_valid exactly 5 cycles after u_start with rsp_sin=rsp_cos=0 and rsp_err=1; a u_done injected afterwards produces no response.
REQ-031 Coincidence: u_done in the same cycle the counter hits TIMEOUT_CYC -> rsp_err=0 and the unit results are forwarded.
REQ-032 Reset mid-WAIT: n_rst pulsed low -> all outputs 0 immediately; no rsp pulse; a following u_done is ignored; the next tie goes to requester 0.
REQ-033 Spurious done: u_done=1 while IDLE -> no state change; busy stays 0.
